// File: rtl/clock_divider_multi.sv
// Multi-channel programmable clock divider: each channel produces a 50% duty square
// wave with a runtime-loadable half-period, a run enable, and a rising-edge tick.
module clock_divider_multi #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int DEFAULT_FREQ = 2,
    parameter int CHANNELS     = 4,
    parameter int CNT_W        = 32,
    localparam int LCH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] en,
    input  logic                restart,
    input  logic                load,
    input  logic [LCH_W-1:0]    load_ch,
    input  logic [CNT_W-1:0]    load_val,
    output logic [CHANNELS-1:0] clk_div,
    output logic [CHANNELS-1:0] tick,
    output logic                load_err
);

    localparam int               DH_RAW       = CLK_FREQ / (2 * DEFAULT_FREQ);
    localparam logic [CNT_W-1:0] DEFAULT_HALF = (DH_RAW < 1) ? CNT_W'(1) : CNT_W'(DH_RAW);

    logic [CNT_W-1:0] hp  [CHANNELS];
    logic [CNT_W-1:0] cnt [CHANNELS];
    logic             load_ok;

    assign load_ok = load && (load_val != '0) && (int'(load_ch) < CHANNELS);

    // Restart beats the run logic but never blocks a load from updating hp, so a
    // combined restart+load leaves every channel aligned with the new rate active.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                hp[i]  <= DEFAULT_HALF;
                cnt[i] <= '0;
            end
            clk_div  <= '0;
            tick     <= '0;
            load_err <= 1'b0;
        end else begin
            load_err <= load && !load_ok;
            for (int i = 0; i < CHANNELS; i++) begin
                if (load_ok && (int'(load_ch) == i)) begin
                    hp[i] <= load_val;
                end

                if (restart) begin
                    cnt[i]     <= '0;
                    clk_div[i] <= 1'b0;
                    tick[i]    <= 1'b0;
                end else if (load_ok && (int'(load_ch) == i)) begin
                    cnt[i]  <= '0;
                    tick[i] <= 1'b0;
                end else if (en[i]) begin
                    // >= rather than == so a count left above a shrunk hp still wraps
                    if (cnt[i] >= hp[i] - CNT_W'(1)) begin
                        cnt[i]     <= '0;
                        clk_div[i] <= ~clk_div[i];
                        tick[i]    <= ~clk_div[i];
                    end else begin
                        cnt[i]  <= cnt[i] + CNT_W'(1);
                        tick[i] <= 1'b0;
                    end
                end else begin
                    tick[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Self-checking bench for clock_divider_multi: a countdown reference model feeds a
// scoreboard of expected {clk_div, tick, load_err} for every clock edge.
module tb_clock_divider_multi;

    localparam int DH = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  en;
    logic        restart;
    logic        load;
    logic [1:0]  load_ch;
    logic [31:0] load_val;
    logic [3:0]  clk_div;
    logic [3:0]  tick;
    logic        load_err;

    logic [2:0]  en3;
    logic        load3;
    logic [1:0]  load_ch3;
    logic [31:0] load_val3;
    logic [2:0]  clk_div3;
    logic [2:0]  tick3;
    logic        load_err3;

    logic [3:0]  m_div;
    int          m_rem [4];
    int          m_hp  [4];
    logic [8:0]  sb [$];
    int          checks = 0;
    int          errors = 0;

    clock_divider_multi #(.CLK_FREQ(12), .DEFAULT_FREQ(2), .CHANNELS(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .en(en), .restart(restart), .load(load),
        .load_ch(load_ch), .load_val(load_val),
        .clk_div(clk_div), .tick(tick), .load_err(load_err)
    );

    clock_divider_multi #(.CLK_FREQ(12), .DEFAULT_FREQ(2), .CHANNELS(3), .CNT_W(32)) dut3 (
        .clk(clk), .rst(rst), .en(en3), .restart(1'b0), .load(load3),
        .load_ch(load_ch3), .load_val(load_val3),
        .clk_div(clk_div3), .tick(tick3), .load_err(load_err3)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_div = '0;
        for (int i = 0; i < 4; i++) begin
            m_hp[i]  = DH;
            m_rem[i] = DH;
        end
        sb.delete();
    endtask

    // Drives one cycle of stimulus, advances the model and queues the expected outputs.
    task automatic drive_cycle(input logic [3:0] e, input logic rs, input logic ld,
                               input logic [1:0] lc, input logic [31:0] lv);
        logic       ok;
        logic [3:0] t;
        @(negedge clk);
        en = e; restart = rs; load = ld; load_ch = lc; load_val = lv;
        ok = ld && (lv != 0);
        t  = '0;
        for (int i = 0; i < 4; i++) begin
            if (ok && int'(lc) == i) m_hp[i] = int'(lv);
            if (rs) begin
                m_div[i] = 1'b0;
                m_rem[i] = m_hp[i];
            end else if (ok && int'(lc) == i) begin
                m_rem[i] = m_hp[i];
            end else if (e[i]) begin
                m_rem[i]--;
                if (m_rem[i] == 0) begin
                    m_div[i] = ~m_div[i];
                    t[i]     = m_div[i];
                    m_rem[i] = m_hp[i];
                end
            end
        end
        sb.push_back({m_div, t, ld && !ok});
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = '0; restart = 0; load = 0; load_ch = '0; load_val = '0;
        en3 = '0; load3 = 0; load_ch3 = '0; load_val3 = '0;
        #12;
        checks++;
        if ({clk_div, tick, load_err} !== 9'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b, expected 0", {clk_div, tick, load_err});
        end
        checks++;
        if ({clk_div3, tick3, load_err3} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs3: got %b, expected 0", {clk_div3, tick3, load_err3});
        end
        model_reset();
        @(posedge clk); #3; rst = 1'b0;
    endtask

    task automatic test_default_run();
        logic [8:0] exp;
        int first_rise = -1;
        int ticks = 0;
        for (int c = 1; c <= 14; c++) begin
            drive_cycle(4'hF, 0, 0, 2'd0, 0);
            #1; exp = sb.pop_front(); checks++;
            if ({clk_div, tick, load_err} !== exp) begin
                errors++;
                $display("[TB] FAIL default_run c%0d: got %b, expected %b", c, {clk_div, tick, load_err}, exp);
            end
            if (first_rise < 0 && clk_div[0]) first_rise = c;
            if (c <= 12 && tick[0]) ticks++;
        end
        checks++;
        if (first_rise != 3) begin
            errors++;
            $display("[TB] FAIL default_first_rise: got edge %0d, expected 3", first_rise);
        end
        checks++;
        if (ticks != 2) begin
            errors++;
            $display("[TB] FAIL default_tick_count: got %0d, expected 2", ticks);
        end
    endtask

    task automatic test_load();
        logic [8:0] exp;
        logic prev;
        int change = -1;
        drive_cycle(4'hF, 0, 1, 2'd1, 5);
        #1; exp = sb.pop_front(); checks++;
        if ({clk_div, tick, load_err} !== exp) begin
            errors++;
            $display("[TB] FAIL load_edge: got %b, expected %b", {clk_div, tick, load_err}, exp);
        end
        prev = exp[6];
        for (int c = 1; c <= 16; c++) begin
            drive_cycle(4'hF, 0, 0, 2'd0, 0);
            #1; exp = sb.pop_front(); checks++;
            if ({clk_div, tick, load_err} !== exp) begin
                errors++;
                $display("[TB] FAIL load_run c%0d: got %b, expected %b", c, {clk_div, tick, load_err}, exp);
            end
            if (change < 0 && clk_div[1] !== prev) change = c;
        end
        checks++;
        if (change != 5) begin
            errors++;
            $display("[TB] FAIL load_first_toggle: got edge %0d, expected 5", change);
        end
    endtask

    task automatic test_min_and_invalid();
        logic [8:0] exp;
        int ticks = 0;
        drive_cycle(4'hF, 0, 1, 2'd0, 1);
        #1; void'(sb.pop_front());
        for (int c = 1; c <= 6; c++) begin
            drive_cycle(4'hF, 0, 0, 2'd0, 0);
            #1; exp = sb.pop_front(); checks++;
            if ({clk_div, tick, load_err} !== exp) begin
                errors++;
                $display("[TB] FAIL min_div c%0d: got %b, expected %b", c, {clk_div, tick, load_err}, exp);
            end
            if (tick[0]) ticks++;
        end
        checks++;
        if (ticks != 3) begin
            errors++;
            $display("[TB] FAIL min_div_ticks: got %0d, expected 3", ticks);
        end
        drive_cycle(4'hF, 0, 1, 2'd2, 0);
        #1; exp = sb.pop_front(); checks++;
        if ({clk_div, tick, load_err} !== exp || load_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL zero_load_err: got %b, expected %b", {clk_div, tick, load_err}, exp);
        end
        for (int c = 1; c <= 8; c++) begin
            drive_cycle(4'hF, 0, 0, 2'd0, 0);
            #1; exp = sb.pop_front(); checks++;
            if ({clk_div, tick, load_err} !== exp) begin
                errors++;
                $display("[TB] FAIL zero_load_after c%0d: got %b, expected %b", c, {clk_div, tick, load_err}, exp);
            end
        end
    endtask

    task automatic test_invalid_channel();
        logic [8:0] exp;
        int first = -1;
        drive_cycle(4'h0, 0, 0, 2'd0, 0);
        #1; exp = sb.pop_front(); checks++;
        if ({clk_div, tick, load_err} !== exp) begin
            errors++;
            $display("[TB] FAIL freeze_main: got %b, expected %b", {clk_div, tick, load_err}, exp);
        end
        @(negedge clk); load3 = 1; load_ch3 = 2'd3; load_val3 = 7;
        @(posedge clk); #1; checks++;
        if (load_err3 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bad_ch_err: got %b, expected 1", load_err3);
        end
        @(negedge clk); load3 = 0;
        @(posedge clk); #1; checks++;
        if ({clk_div3, tick3, load_err3} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL bad_ch_after: got %b, expected 0", {clk_div3, tick3, load_err3});
        end
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk); en3 = 3'b111;
            @(posedge clk); #1;
            if (first < 0 && clk_div3 == 3'b111) first = c;
        end
        checks++;
        if (first != 3) begin
            errors++;
            $display("[TB] FAIL bad_ch_unchanged: first rise edge %0d, expected 3", first);
        end
    endtask

    task automatic test_enable_gating();
        logic [8:0] exp;
        for (int c = 1; c <= 20; c++) begin
            drive_cycle((c >= 3 && c <= 6) ? 4'hB : 4'hF, 0, 0, 2'd0, 0);
            #1; exp = sb.pop_front(); checks++;
            if ({clk_div, tick, load_err} !== exp) begin
                errors++;
                $display("[TB] FAIL gating c%0d: got %b, expected %b", c, {clk_div, tick, load_err}, exp);
            end
            if (c >= 3 && c <= 6) begin
                checks++;
                if (tick[2] !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL gating_tick c%0d: got %b, expected 0", c, tick[2]);
                end
            end
        end
    endtask

    task automatic test_restart_load();
        logic [8:0] exp;
        drive_cycle(4'hF, 0, 1, 2'd0, 3);
        #1; void'(sb.pop_front());
        for (int c = 1; c <= 2; c++) begin
            drive_cycle(4'hF, 0, 0, 2'd0, 0);
            #1; void'(sb.pop_front());
        end
        drive_cycle(4'hF, 1, 1, 2'd3, 2);
        #1; exp = sb.pop_front(); checks++;
        if ({clk_div, tick, load_err} !== exp || clk_div !== 4'b0) begin
            errors++;
            $display("[TB] FAIL restart_clear: got %b, expected %b", {clk_div, tick, load_err}, exp);
        end
        for (int c = 1; c <= 10; c++) begin
            drive_cycle(4'hF, 0, 0, 2'd0, 0);
            #1; exp = sb.pop_front(); checks++;
            if ({clk_div, tick, load_err} !== exp || clk_div[0] !== clk_div[2]) begin
                errors++;
                $display("[TB] FAIL restart_run c%0d: got %b, expected %b", c, {clk_div, tick, load_err}, exp);
            end
            if (c == 2) begin
                checks++;
                if (clk_div[3] !== 1'b1 || tick[3] !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL restart_ch3_rise: got div=%b tick=%b, expected 1 1", clk_div[3], tick[3]);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [8:0] exp;
        int first = -1;
        for (int c = 1; c <= 8 && m_div[1] == 1'b0; c++) begin
            drive_cycle(4'hF, 0, 0, 2'd0, 0);
            #1; void'(sb.pop_front());
        end
        #2; rst = 1'b1; #1; checks++;
        if ({clk_div, tick, load_err} !== 9'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: got %b, expected 0 (model div was %b)", {clk_div, tick, load_err}, m_div);
        end
        model_reset();
        @(posedge clk); #3; rst = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            drive_cycle(4'hF, 0, 0, 2'd0, 0);
            #1; exp = sb.pop_front(); checks++;
            if ({clk_div, tick, load_err} !== exp) begin
                errors++;
                $display("[TB] FAIL post_reset c%0d: got %b, expected %b", c, {clk_div, tick, load_err}, exp);
            end
            if (first < 0 && clk_div == 4'hF) first = c;
        end
        checks++;
        if (first != 3) begin
            errors++;
            $display("[TB] FAIL post_reset_rise: got edge %0d, expected 3", first);
        end
    endtask

    initial begin
        test_reset();
        test_default_run();
        test_load();
        test_min_and_invalid();
        test_invalid_channel();
        test_enable_gating();
        test_restart_load();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_divider_multi.md
# clock_divider_multi

Multi-channel, runtime-programmable clock divider for the robot-arm controller. It generates CHANNELS independent square-wave enables, such as servo PWM frame clocks or the step/blink rates, from the 50 MHz system clock. Each channel has its own half-period, an enable, and a one-cycle tick pulse. A global synchronous restart phase-aligns all channels. It replaces the fixed single-frequency divider in designs that need several rates or need to change a rate without resynthesis.

## Interface
- CLK_FREQ, 50_000_000, input clock frequency in Hz.
- DEFAULT_FREQ, 2, output frequency in Hz of every channel after reset.
- CHANNELS, 4, number of independent divider channels, ≥1.
- CNT_W, 32, width of the half-period registers and counters.
- DEFAULT_HALF (localparam), CLK_FREQ/(2*DEFAULT_FREQ), clamped to a minimum of 1.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  CHANNELS  per-channel run enable.
- restart  in  1  synchronous phase-align strobe for all channels.
- load  in  1  write strobe for one half-period register.
- load_ch  in  max(1,$clog2(CHANNELS))  channel index for load.
- load_val  in  CNT_W  new half-period in clk cycles.
- clk_div  out  CHANNELS  divided square waves, registered.
- tick  out  CHANNELS  one-cycle pulse when clk_div[i] rises, registered.
- load_err  out  1  one-cycle pulse flagging a rejected load.

## Operation
- Per channel i: half-period register hp[i], counter cnt[i], output clk_div[i].
- Reset values:
  - hp[i]=DEFAULT_HALF.
  - cnt[i]=0.
  - clk_div=0.
  - tick=0.
  - load_err=0.
- Run, when en[i]=1:
  - If cnt[i] ≥ hp[i]-1: cnt[i]←0 and clk_div[i] toggles.
  - Otherwise: cnt[i]←cnt[i]+1.
  - The ≥ comparison guards against a stale count after any hp change.
- tick[i]=1 for exactly the cycle in which clk_div[i] becomes 1, registered alongside it. It is 0 on falling toggles and at all other times.
- Hold, when en[i]=0: cnt[i] and clk_div[i] freeze and tick[i]=0. On re-enable, counting resumes from the held count. There is no phase loss.
- Load, when load=1:
  - Valid load (load_ch < CHANNELS and load_val ≠ 0): hp[load_ch]←load_val and cnt[load_ch]←0 on the same edge. clk_div[load_ch] is unchanged, so the new half-period begins immediately. The load applies even when that channel is disabled.
  - Invalid load (load_ch ≥ CHANNELS or load_val=0): no state changes and load_err pulses for 1 cycle.
- Restart, when restart=1: every cnt←0, every clk_div←0, tick←0, regardless of en. hp values are kept.
- Restart and load in the same cycle: restart clears all counters and outputs, and the load still updates hp. Result: all channels aligned, with the new hp in effect.
- Restart has priority over the run/toggle logic in that cycle.
- Counter arithmetic is unsigned CNT_W. hp=1 gives a toggle every cycle, i.e. clk/2.

## Timing
- With en[i] held at 1, clk_div[i] has a period of 2*hp[i] clk cycles and a 50% duty cycle.
- Latency after rst deassert, or after a restart edge, with en=1: the first rising toggle of clk_div[i] occurs on the hp[i]-th rising clk edge, with tick[i] high in that same cycle.
- Falling toggle: hp[i] edges after the rising toggle.
- Valid load at edge E: the next toggle of that channel occurs on edge E+hp_new.
- load_err is asserted in the cycle after the offending load edge, for 1 cycle.
- rst asserted mid-count or mid-high-phase: all outputs go to 0 immediately (asynchronously) and hp returns to DEFAULT_HALF.
- No combinational path from any input to any output.

## Test plan
- Reset and default run: CLK_FREQ=12, DEFAULT_FREQ=2 (DEFAULT_HALF=3), en=all 1. Required: clk_div[i] period is 6 cycles, the first rise is on the 3rd edge after rst release, and tick is high 1 cycle per period.
- Load: load ch1 with load_val=5 mid-count. Required: ch1 toggles 5 edges after the load and then every 5 edges. Other channels are undisturbed.
- Minimum divider and invalid loads:
  - load_val=1 on ch0: required clk_div[0] toggles every cycle, tick every 2nd cycle.
  - load_val=0: required load_err pulse and hp unchanged.
  - load_ch=CHANNELS: required load_err pulse and no change to any channel.
- Enable gating: drop en[2] for 4 cycles mid-period. Required: clk_div[2] and cnt hold, tick[2]=0 throughout, and the period is stretched by exactly 4 cycles.
- Restart plus load: channels at different phases; apply restart and load ch3 with 2 in the same cycle. Required: all clk_div=0 next cycle, channels with equal hp rise together, and ch3 rises 2 edges after the restart.
- Asynchronous reset: assert rst mid-high-phase after hp changes. Required: immediate clk_div=0, tick=0, and after release the DEFAULT_HALF timing is restored.
